// File: rtl/svc_pkg.sv
// Shared types and default phase constants for the service-gate sequencer.
// Optional monitor outputs are enabled in the top with SVC_MONITOR_EN.
package svc_pkg;

  localparam int unsigned NPHASE_DEF = 4;
  localparam int unsigned PH_W_DEF   = $clog2(NPHASE_DEF);

  typedef logic [PH_W_DEF-1:0] phase_t;

  localparam int unsigned RT_PH_DEF  = 1;
  localparam int unsigned CLR_PH_DEF = 2;
  localparam int unsigned WT_PH_DEF  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/svc_addr_decode.sv
// One-hot decoder from a register index to NREG select lines; indices at or
// beyond NREG decode to all zeros.
module svc_addr_decode
  import svc_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREG   = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [NREG-1:0]   dec_o
);

  always_comb begin
    dec_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (en_i && (32'(addr_i) == i)) begin
        dec_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svc_gate_sequencer.sv
// Sequences one register-transfer command per memory cycle into read, clear and
// write gates plus the carry-in flip-flop. Define SVC_MONITOR_EN for monitor taps.
module svc_gate_sequencer
  import svc_pkg::*;
#(
  parameter int unsigned NREG   = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NPHASE = NPHASE_DEF,
  parameter int unsigned RT_PH  = RT_PH_DEF,
  parameter int unsigned CLR_PH = CLR_PH_DEF,
  parameter int unsigned WT_PH  = WT_PH_DEF,
  parameter int unsigned U_IDX  = 7
) (
  input  logic                       SIM_CLK,
  input  logic                       SIM_RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [NREG-1:0]            cmd_rd,
  input  logic [NREG-1:0]            cmd_wr,
  input  logic                       cmd_sc,
  input  logic                       cmd_sc_wr,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic                       cmd_ci,
  output logic [NREG-1:0]            rd_gate_n,
  output logic [NREG-1:0]            clr_gate,
  output logic [NREG-1:0]            wr_gate_n,
  output logic                       ci01_n,
  output logic [$clog2(NPHASE)-1:0]  phase,
  output logic                       busy,
  output logic                       cyc_done
`ifdef SVC_MONITOR_EN
  ,
  output logic [NREG-1:0]            mon_rd,
  output logic [NREG-1:0]            mon_wr,
  output logic                       mon_ci
`endif
);

  localparam int unsigned     PH_W   = $clog2(NPHASE);
  localparam logic [PH_W-1:0] LAST   = PH_W'(NPHASE - 1);
  localparam logic [NREG-1:0] U_MASK = NREG'(1) << U_IDX;

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [NREG-1:0] rdm_q, rdm_d, wrm_q, wrm_d;
  logic            ci_q, ci_d;
  logic [NREG-1:0] rd_gate_n_q, rd_gate_n_d;
  logic [NREG-1:0] clr_gate_q, clr_gate_d;
  logic [NREG-1:0] wr_gate_n_q, wr_gate_n_d;
  logic            ci01_n_q, ci01_n_d;
  logic            busy_q, busy_d;
  logic            cyc_done_q, cyc_done_d;
  logic            run_d;
  logic [NREG-1:0] sc_dec;
  logic            accept;
`ifdef SVC_MONITOR_EN
  logic [NREG-1:0] mon_rd_q, mon_rd_d, mon_wr_q, mon_wr_d;
`endif

  svc_addr_decode #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_addr_decode (
    .addr_i (cmd_addr),
    .en_i   (cmd_sc),
    .dec_o  (sc_dec)
  );

  // Ready on the last phase lets the next command start without a bubble.
  assign cmd_ready = !SIM_RST && ((state_q == IDLE) || (phase_q == LAST));
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rdm_d    = rdm_q;
    wrm_d    = wrm_q;
    ci_d     = ci_q;
    ci01_n_d = ci01_n_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          phase_d = '0;
        end
      end
      RUN: begin
        if (phase_q == LAST) begin
          phase_d = '0;
          if (!accept) state_d = IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
    endcase

    if (accept) begin
      rdm_d = cmd_rd | (cmd_sc_wr ? '0 : sc_dec);
      wrm_d = cmd_wr | (cmd_sc_wr ? sc_dec : '0);
      ci_d  = cmd_ci;
    end

    // Gates are registered so they line up with the phase they belong to.
    run_d       = (state_d == RUN);
    rd_gate_n_d = (run_d && (phase_d == PH_W'(RT_PH)))  ? ~rdm_d : '1;
    clr_gate_d  = (run_d && (phase_d == PH_W'(CLR_PH))) ?  wrm_d : '0;
    wr_gate_n_d = (run_d && (phase_d == PH_W'(WT_PH)))  ? ~wrm_d : '1;
    busy_d      = run_d;
    cyc_done_d  = run_d && (phase_d == LAST);

    if (|(clr_gate_q & U_MASK)) ci01_n_d = 1'b1;
    if ((state_q == RUN) && (phase_q == PH_W'(WT_PH)) && ci_q) ci01_n_d = 1'b0;

`ifdef SVC_MONITOR_EN
    mon_rd_d = ~rd_gate_n_q;
    mon_wr_d = ~wr_gate_n_q;
`endif
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      rdm_q       <= '0;
      wrm_q       <= '0;
      ci_q        <= 1'b0;
      rd_gate_n_q <= '1;
      clr_gate_q  <= '0;
      wr_gate_n_q <= '1;
      ci01_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      cyc_done_q  <= 1'b0;
`ifdef SVC_MONITOR_EN
      mon_rd_q    <= '0;
      mon_wr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rdm_q       <= rdm_d;
      wrm_q       <= wrm_d;
      ci_q        <= ci_d;
      rd_gate_n_q <= rd_gate_n_d;
      clr_gate_q  <= clr_gate_d;
      wr_gate_n_q <= wr_gate_n_d;
      ci01_n_q    <= ci01_n_d;
      busy_q      <= busy_d;
      cyc_done_q  <= cyc_done_d;
`ifdef SVC_MONITOR_EN
      mon_rd_q    <= mon_rd_d;
      mon_wr_q    <= mon_wr_d;
`endif
    end
  end

  assign rd_gate_n = rd_gate_n_q;
  assign clr_gate  = clr_gate_q;
  assign wr_gate_n = wr_gate_n_q;
  assign ci01_n    = ci01_n_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign cyc_done  = cyc_done_q;
`ifdef SVC_MONITOR_EN
  assign mon_rd    = mon_rd_q;
  assign mon_wr    = mon_wr_q;
  assign mon_ci    = ~ci01_n_q;
`endif

endmodule
